// File: rtl/mem_responder.sv
// Memory-mapped responder for a small CPU: RAM with INIT clear, host program load,
// and CPU accesses to RAM plus a synchronized input port and a registered output port.
module mem_responder #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              CS,
  input  logic              R_NW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WORD_W-1:0] host_data,
  input  logic              host_go,
  input  logic [WORD_W-1:0] in_port,
  output logic [WORD_W-1:0] out_port,
  output logic              cpu_n_reset,
  output logic              ready,
  output logic              wr_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] RAM_TOP  = ADDR_W'(DEPTH - 3);
  localparam logic [ADDR_W-1:0] IN_ADDR  = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr;
  logic [WORD_W-1:0]   r_sync1;
  logic [WORD_W-1:0]   r_sync2;
  logic [WORD_W-1:0]   r_mem [DEPTH];

  logic                w_cpu_rd;
  logic                w_cpu_wr;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [WORD_W-1:0]   w_mem_data;
  logic [WORD_W-1:0]   w_rd_src;

  assign w_cpu_rd = (r_state == ST_RUN) && CS && R_NW;
  assign w_cpu_wr = (r_state == ST_RUN) && CS && !R_NW;
  assign ready    = (r_state == ST_LOAD);

  // Single RAM write port shared by INIT clear, host load and CPU writes.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = r_clr;
    w_mem_data = '0;
    case (r_state)
      ST_INIT: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_clr;
        w_mem_data = '0;
      end
      ST_LOAD: begin
        w_mem_we   = host_we && (host_addr <= RAM_TOP);
        w_mem_addr = host_addr;
        w_mem_data = host_data;
      end
      ST_RUN: begin
        w_mem_we   = w_cpu_wr && (addr <= RAM_TOP);
        w_mem_addr = addr;
        w_mem_data = wdata;
      end
      default: begin
        w_mem_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_comb begin
    w_rd_src = r_mem[addr];
    if (addr == IN_ADDR) begin
      w_rd_src = r_sync2;
    end else if (addr == OUT_ADDR) begin
      w_rd_src = out_port;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= ST_INIT;
      r_clr       <= '0;
      rdata       <= '0;
      out_port    <= '0;
      wr_err      <= 1'b0;
      cpu_n_reset <= 1'b0;
    end else begin
      cpu_n_reset <= (r_state == ST_RUN);
      case (r_state)
        ST_INIT: begin
          if (r_clr == RAM_TOP) begin
            r_state <= ST_LOAD;
          end else begin
            r_clr <= r_clr + 1'b1;
          end
        end
        ST_LOAD: begin
          if (host_go) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_cpu_rd) begin
            rdata <= w_rd_src;
          end
          if (w_cpu_wr) begin
            if (addr == OUT_ADDR) begin
              out_port <= wdata;
            end else if (addr == IN_ADDR) begin
              wr_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

endmodule
